mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, memory read latency in cycles after mem_en asserts (legal 0..15).
REQ-002 Parameter: AW, default 32, address/data width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 if_req  input  1  fetch request, held high with stable if_addr until if_ack.
REQ-007 if_addr  input  AW  fetch address.
REQ-008 if_gnt  output  1  fetch owns memory (ACCESS or DONE).
REQ-009 if_rdata  output  AW  registered fetch data, valid with if_ack.
REQ-010 if_ack  output  1  one-cycle fetch completion pulse.
REQ-011 dm_req  input  1  data request, held with stable dm_we/dm_addr/dm_wdata until dm_ack.
REQ-012 dm_we  input  1  1 = store, 0 = load.
REQ-013 dm_addr, dm_wdata  input  AW each  data address, store data.
REQ-014 dm_gnt  output  1  data port owns memory.
REQ-015 dm_rdata  output  AW  registered load data, valid with dm_ack.
REQ-016 dm_ack  output  1  one-cycle data completion pulse (loads and stores).
REQ-017 mem_en, mem_we  output  1 each  memory enable, write enable.
REQ-018 mem_addr, mem_wdata  output  AW each  latched address, store data.
REQ-019 mem_rdata  input  AW  memory read data.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-022 IDLE: if any req high, SHALL latch winner's addr/we/wdata and move to ACCESS next cycle; else stay.
REQ-023 ACCESS: mem_en=1, mem_we=latched we (fetch always 0); 4-bit counter counts 0..WAIT_CYCLES; at count==WAIT_CYCLES SHALL capture mem_rdata into winner's rdata register and move to DONE.
REQ-024 DONE: winner's ack=1 for exactly one cycle, mem_en=0; next state IDLE unconditionally.
REQ-025 Latency: req sampled in IDLE at cycle t -> ack at cycle t+WAIT_CYCLES+2 (t+4 at default); back-to-back accesses SHALL cost WAIT_CYCLES+3 cycles each.
REQ-026 WAIT_CYCLES=0: ACCESS SHALL last exactly one cycle.
REQ-027 Exactly one of if_gnt/dm_gnt SHALL be high in ACCESS/DONE; both low in IDLE.
REQ-028 Store: mem_we=1 for every ACCESS cycle; dm_rdata SHALL keep its previous value.
REQ-029 Non-winner rdata register SHALL hold its value.
REQ-030 Requester dropping req mid-access: access SHALL complete and ack SHALL still pulse.
REQ-031 Requests arriving outside IDLE SHALL wait; inputs changing during ACCESS SHALL not affect the latched transaction.
REQ-032 Contention in IDLE (both req high): resolved per REQ-036/037.

Reset
REQ-033 rst=1 SHALL force IDLE, counter 0, all gnt/ack/mem_en/mem_we/busy 0, rdata registers 0, mem_addr/mem_wdata 0, last-grant flag = fetch.
REQ-034 Reset during ACCESS SHALL abort: mem_en and mem_we low from the next edge, no ack issued.
REQ-035 Reset has priority over every other transition.

Configuration
REQ-036 Macro ARB_ROUND_ROBIN_EN defined: on contention the port not granted last SHALL win; last-grant flag updates on each grant; first contention after reset goes to data.
REQ-037 Macro undefined: fixed priority, data port SHALL always win contention; last-grant flag absent.

Verification
REQ-038 Single load, WAIT_CYCLES=2: dm_req at t, addr 0x40, mem_rdata 0xDEADBEEF -> dm_ack at t+4, dm_rdata=0xDEADBEEF, mem_en high t+1..t+3.
REQ-039 Store: dm_we=1, addr 0x80, wdata 0x12345678 -> mem_we=1 with mem_addr=0x80, mem_wdata=0x12345678 for 3 cycles, dm_ack at t+4.
REQ-040 Both req held continuously: macro undefined -> data served every time, fetch never acked; macro defined -> acks alternate dm, if, dm, if.
REQ-041 rst asserted at 2nd ACCESS cycle -> next edge mem_en=0, busy=0, no ack; rdata registers 0.
REQ-042 WAIT_CYCLES=0 fetch: if_req at t -> mem_en high only at t+1, if_ack at t+2.
REQ-043 if_req dropped at t+2 mid-access -> if_ack still at t+4, arbiter IDLE at t+5.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single fixed-latency memory.
// Contention goes to data unless ARB_ROUND_ROBIN_EN is defined, which alternates winners.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [AW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [AW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic [AW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES);

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic       owner_dm_reg;
    logic       win_dm;

`ifdef ARB_ROUND_ROBIN_EN
    // last_dm_reg = 1 when the data port received the most recent grant
    logic last_dm_reg;
    assign win_dm = dm_req && (!if_req || !last_dm_reg);
`else
    assign win_dm = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            owner_dm_reg <= 1'b0;
            if_gnt       <= 1'b0;
            dm_gnt       <= 1'b0;
            if_ack       <= 1'b0;
            dm_ack       <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            busy         <= 1'b0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (if_req || dm_req) begin
                        owner_dm_reg <= win_dm;
                        mem_addr     <= win_dm ? dm_addr : if_addr;
                        mem_wdata    <= win_dm ? dm_wdata : '0;
                        mem_we       <= win_dm && dm_we;
                        mem_en       <= 1'b1;
                        if_gnt       <= !win_dm;
                        dm_gnt       <= win_dm;
                        busy         <= 1'b1;
                        cnt_reg      <= 4'd0;
                        state_reg    <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                        last_dm_reg  <= win_dm;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_reg == LAST_COUNT) begin
                        // Stores complete with an ack but leave the load data register alone
                        if (owner_dm_reg) begin
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_ack <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    if_ack    <= 1'b0;
                    dm_ack    <= 1'b0;
                    if_gnt    <= 1'b0;
                    dm_gnt    <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES 2 and 0) on shared requests,
// each checked every cycle against a transaction-timeline model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] if_addr;
    logic [AW-1:0] dm_addr;
    logic [AW-1:0] dm_wdata;

    int checks = 0;
    int errors = 0;

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hDEADBEAF;
    endfunction

    function automatic bit pick_dm(input bit ir, input bit dr, input bit last_dm);
`ifdef ARB_ROUND_ROBIN_EN
        if (ir && dr) return !last_dm;
`endif
        return dr;
    endfunction

    task automatic chk(input int inst, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %h expected %h (t=%0t)", inst, name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int W = (gi == 0) ? 2 : 0;

        logic          if_gnt, if_ack, dm_gnt, dm_ack, mem_en, mem_we, busy;
        logic [AW-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
        int            run;

        bit            m_active, m_owner_dm, m_we, m_last_dm;
        int            m_k;
        logic [31:0]   m_addr, m_wdata, m_if_rd, m_dm_rd;

        mem_arbiter #(.WAIT_CYCLES(W), .AW(AW)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
            .if_rdata(if_rdata), .if_ack(if_ack),
            .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
            .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
        );

        // Memory returns valid data only in the W-th enabled cycle, noise otherwise
        always @(negedge clk) begin
            if (mem_en) begin
                mem_rdata <= (run == W) ? mem_f(mem_addr) : $urandom;
                run       <= run + 1;
            end else begin
                run       <= 0;
                mem_rdata <= $urandom;
            end
        end

        // Timeline model: a grant opens W+1 access cycles, one done cycle, then idle
        always @(posedge clk) begin
            if (rst) begin
                m_active   <= 1'b0;
                m_k        <= 0;
                m_owner_dm <= 1'b0;
                m_we       <= 1'b0;
                m_last_dm  <= 1'b0;
                m_addr     <= '0;
                m_wdata    <= '0;
                m_if_rd    <= '0;
                m_dm_rd    <= '0;
            end else if (!m_active) begin
                if (if_req || dm_req) begin
                    m_owner_dm <= pick_dm(if_req, dm_req, m_last_dm);
                    m_last_dm  <= pick_dm(if_req, dm_req, m_last_dm);
                    m_addr     <= pick_dm(if_req, dm_req, m_last_dm) ? dm_addr : if_addr;
                    m_wdata    <= pick_dm(if_req, dm_req, m_last_dm) ? dm_wdata : '0;
                    m_we       <= pick_dm(if_req, dm_req, m_last_dm) && dm_we;
                    m_active   <= 1'b1;
                    m_k        <= 0;
                end
            end else begin
                if (m_k == W) begin
                    if (m_owner_dm) begin
                        if (!m_we) m_dm_rd <= mem_f(m_addr);
                    end else begin
                        m_if_rd <= mem_f(m_addr);
                    end
                end
                if (m_k == W + 1) m_active <= 1'b0;
                else              m_k      <= m_k + 1;
            end
        end

        always @(negedge clk) begin
            chk(gi, "busy",      busy,      m_active);
            chk(gi, "if_gnt",    if_gnt,    m_active && !m_owner_dm);
            chk(gi, "dm_gnt",    dm_gnt,    m_active && m_owner_dm);
            chk(gi, "mem_en",    mem_en,    m_active && m_k <= W);
            chk(gi, "mem_we",    mem_we,    m_active && m_k <= W && m_we);
            chk(gi, "if_ack",    if_ack,    m_active && m_k == W + 1 && !m_owner_dm);
            chk(gi, "dm_ack",    dm_ack,    m_active && m_k == W + 1 && m_owner_dm);
            chk(gi, "if_rdata",  if_rdata,  m_if_rd);
            chk(gi, "dm_rdata",  dm_rdata,  m_dm_rd);
            chk(gi, "mem_addr",  mem_addr,  m_addr);
            chk(gi, "mem_wdata", mem_wdata, m_wdata);
            if (m_active && m_k == W + 1)
                $display("txn inst%0d W=%0d %s %s addr=%h data=%h", gi, W,
                         m_owner_dm ? "dm" : "if", m_we ? "store" : "load", m_addr,
                         m_we ? m_wdata : (m_owner_dm ? m_dm_rd : m_if_rd));
        end
    end

    task automatic drain(input int n);
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issue one request and record the cycle (after the sampling edge) of the first ack per instance
    task automatic run_req(input bit is_dm, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat0, output int lat1);
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat0 = -1;
        lat1 = -1;
        for (int c = 1; c <= 20 && (lat0 < 0 || lat1 < 0); c++) begin
            @(negedge clk);
            if (lat0 < 0 && (is_dm ? g_inst[0].dm_ack : g_inst[0].if_ack)) lat0 = c;
            if (lat1 < 0 && (is_dm ? g_inst[1].dm_ack : g_inst[1].if_ack)) lat1 = c;
        end
        drain(6);
    endtask

    initial begin
        int  lat0, lat1;
        bit  seq[$];

        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(negedge clk);
        chk(0, "reset busy",     g_inst[0].busy,     0);
        chk(0, "reset mem_en",   g_inst[0].mem_en,   0);
        chk(0, "reset dm_rdata", g_inst[0].dm_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single load at 0x40: memory returns 0xDEADBEEF
        run_req(1'b1, 1'b0, 32'h40, 32'h0, lat0, lat1);
        chk(0, "load latency", lat0, 4);
        chk(1, "load latency", lat1, 2);
        chk(0, "load data", g_inst[0].dm_rdata, 32'hDEADBEEF);

        // Store to 0x80: three write cycles then ack, load data untouched
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                chk(0, "store mem_we",    g_inst[0].mem_we,    1);
                chk(0, "store mem_addr",  g_inst[0].mem_addr,  32'h80);
                chk(0, "store mem_wdata", g_inst[0].mem_wdata, 32'h12345678);
            end else begin
                chk(0, "store ack", g_inst[0].dm_ack, 1);
            end
        end
        dm_we = 1'b0;
        drain(6);
        chk(0, "store keeps dm_rdata", g_inst[0].dm_rdata, 32'hDEADBEEF);

        // Fetch at 0x100: zero-wait instance acks two cycles after sampling
        run_req(1'b0, 1'b0, 32'h100, 32'h0, lat0, lat1);
        chk(0, "fetch latency", lat0, 4);
        chk(1, "fetch latency", lat1, 2);
        chk(0, "fetch data", g_inst[0].if_rdata, 32'hDEADBFAF);

        // Fetch request dropped in the second access cycle still completes
        if_req = 1'b1; if_addr = 32'h200;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) if_req = 1'b0;
            if (c == 4) chk(0, "dropped req ack", g_inst[0].if_ack, 1);
            if (c == 5) chk(0, "dropped req idle", g_inst[0].busy, 0);
        end
        drain(4);

        // Reset during the second access cycle aborts the load
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dm_req = 1'b0;
        @(negedge clk);
        chk(0, "abort mem_en",   g_inst[0].mem_en,   0);
        chk(0, "abort busy",     g_inst[0].busy,     0);
        chk(0, "abort dm_ack",   g_inst[0].dm_ack,   0);
        chk(0, "abort dm_rdata", g_inst[0].dm_rdata, 0);
        chk(0, "abort if_rdata", g_inst[0].if_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk(0, "abort no late ack", g_inst[0].dm_ack, 0);
        drain(3);

        // Both ports requesting continuously from reset
        rst = 1'b1;
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        if_addr = 32'h300; dm_addr = 32'h400;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (g_inst[0].dm_ack) seq.push_back(1'b1);
            if (g_inst[0].if_ack) seq.push_back(1'b0);
        end
        chk(0, "contention acks", seq.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk(0, "contention order", seq[i], (i % 2 == 0) ? 1 : 0);
`else
            chk(0, "contention order", seq[i], 1);
`endif
        end
        drain(6);

        // Randomized traffic including occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 99) == 0);
            if_req = ($urandom_range(0, 3) != 0);
            dm_req = ($urandom_range(0, 3) != 0);
            dm_we  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0) if_addr  = $urandom;
            if ($urandom_range(0, 2) == 0) dm_addr  = $urandom;
            if ($urandom_range(0, 2) == 0) dm_wdata = $urandom;
            @(negedge clk);
        end
        rst = 1'b0;
        drain(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
